iot_filter_gen2: RTL
====================

IOT_FILTER_GEN2 -- requirements
Module: iot_filter_gen2

Interface
REQ-001 Parameter BYTES, default 16, number of bytes per data word; the data width DW equals 8*BYTES.
REQ-002 Parameter WORDS, default 8, number of words per round; WORDS SHALL be a power of two, at least 2.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_en  input  1  iot_in carries a valid byte this cycle.
REQ-006 iot_in  input  8  data byte; words arrive MSB byte first.
REQ-007 fn_sel  input  3  function code: 1 MAX, 2 MIN, 3 AVG, 4 EXT, 5 EXC, 6 PMAX, 7 PMIN, 0 no output.
REQ-008 thr_lo, thr_hi  input  DW each  unsigned window bounds for EXT and EXC.
REQ-009 out_ready  input  1  consumer accepts iot_out this cycle.
REQ-010 busy  output  1  block refuses input bytes this cycle.
REQ-011 valid  output  1  iot_out holds a result.
REQ-012 iot_out  output  DW  result word.

Function
REQ-013 A byte SHALL be accepted when in_en=1 and busy=0; bytes offered while busy=1 SHALL be ignored, and the host is responsible for not offering them.
REQ-014 Gaps in in_en SHALL be allowed at any point; the byte and word counters SHALL hold during gaps.
REQ-015 fn_sel, thr_lo and thr_hi SHALL be captured with the first accepted byte after reset and held until the next reset.
REQ-016 A word SHALL be complete on its BYTES-th accepted byte; a round SHALL be complete on its WORDS-th complete word; both counters wrap to 0.
REQ-017 MAX and MIN SHALL output the unsigned extreme of the round; a new round SHALL restart from the round's first word.
REQ-018 AVG SHALL output floor(sum/WORDS); the accumulator SHALL be DW+log2(WORDS) bits wide, with no overflow loss.
REQ-019 EXT SHALL output each word for which thr_lo < word < thr_hi, strictly.
REQ-020 EXC SHALL output each word for which word < thr_lo or word > thr_hi, strictly; words equal to either bound SHALL produce no output in either mode.
REQ-021 PMAX: round 0 SHALL output its round maximum and load a peak register with it.
REQ-022 PMAX: each later round SHALL output its round maximum only if it is strictly greater than the peak, and then update the peak.
REQ-023 PMIN SHALL behave as PMAX with the comparison mirrored.
REQ-024 valid SHALL rise in the cycle after the completing byte is accepted.
REQ-025 valid and iot_out SHALL hold stable until the cycle in which valid=1 and out_ready=1, and valid SHALL fall in the cycle after that.
REQ-026 busy SHALL equal valid (registered), so at most one result is pending; with out_ready held at 1, valid and busy are each high for exactly one cycle.
REQ-027 iot_out SHALL be 0 whenever valid=0.
REQ-028 fn_sel=0 SHALL consume data and never assert valid.
REQ-029 If thr_lo >= thr_hi, EXT SHALL never output and EXC SHALL output every word not equal to thr_lo or thr_hi.

Reset
REQ-030 rst SHALL clear the counters, accumulator, round flags, valid, busy and iot_out to 0.
REQ-031 rst SHALL set the peak register to 0 for PMAX and to all-ones for PMIN, and SHALL re-arm the capture of fn_sel and the thresholds.
REQ-032 rst asserted mid-word or mid-round SHALL discard all partial data; the next accepted byte is byte 0 of word 0 of round 0.
REQ-033 rst asserted while valid=1 SHALL drop the pending result without any handshake.

Structure
REQ-034 Function codes, the default BYTES and WORDS, and the accumulator-width function SHALL live in package iotdf_pkg.
REQ-035 Byte-to-word assembly and the word-complete pulse SHALL be sub-module iotdf_word_asm (parameter BYTES).
REQ-036 The comparison, accumulation and output-handshake logic SHALL stay in the top module.

Verification
REQ-037 MAX, default parameters, words 1..8 (word k = k in the LSB), out_ready=1 -> one valid pulse with iot_out=8, one cycle after the 128th byte.
REQ-038 AVG, all 8 words = all-ones -> iot_out = all-ones, showing no overflow.
REQ-039 EXT, thr_lo=0x10, thr_hi=0x20, words 0x10, 0x11, 0x20 -> exactly one output, 0x11.
REQ-040 PMAX over 3 rounds with round maxima 50, 40, 60 -> outputs 50 then 60; no output for round 1.
REQ-041 out_ready held low for 5 cycles after valid rises, with in_en=1 throughout -> valid, busy and iot_out stay stable for those 5 cycles, no bytes are accepted, and the stream resumes correctly after the handshake.
REQ-042 rst pulsed after 70 bytes of MIN, then a clean round -> the result reflects only the post-reset round.

Source files
------------

// File: rtl/iotdf_pkg.sv
// Shared definitions for the IoT data filter: function codes, default sizing, accumulator width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package iotdf_pkg;

   localparam int DEF_BYTES = 16;
   localparam int DEF_WORDS = 8;

   // Function codes carried on fn_sel.
   typedef enum logic [2:0] {
      FN_NONE = 3'd0,
      FN_MAX  = 3'd1,
      FN_MIN  = 3'd2,
      FN_AVG  = 3'd3,
      FN_EXT  = 3'd4,
      FN_EXC  = 3'd5,
      FN_PMAX = 3'd6,
      FN_PMIN = 3'd7
   } fn_e;

   // Width of the AVG accumulator: enough headroom for WORDS full-scale words.
   function automatic int acc_width(input int dw, input int words);
      return dw + $clog2(words);
   endfunction

endpackage

// File: rtl/iotdf_word_asm.sv
// Byte-to-word assembler: shifts accepted bytes (MSB first) into a word, pulses word_vld on the last byte.
// Latency: combinational; word_dat/word_vld are valid in the same cycle as the completing byte.
// Backpressure: none; the caller gates in_vld so only accepted bytes are presented.
// Ports: clk, rst (async, active-high); in_vld/in_byte accepted byte; word_dat/word_vld assembled word.
module iotdf_word_asm
   import iotdf_pkg::*;
#(
   parameter int BYTES = DEF_BYTES,
   localparam int DW = 8 * BYTES
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_vld,
   input  logic [7:0]    in_byte,
   output logic [DW-1:0] word_dat,
   output logic          word_vld
);

   if (BYTES == 1) begin : g_single
      // Every byte is a whole word; nothing to hold.
      assign word_dat = in_byte;
      assign word_vld = in_vld;
   end else begin : g_multi
      localparam int CW = $clog2(BYTES);

      logic [CW-1:0] byte_cnt;
      // Only the first BYTES-1 bytes are ever held; the final byte is merged on the fly.
      logic [DW-9:0] part_q;

      assign word_dat = {part_q, in_byte};
      assign word_vld = in_vld && (byte_cnt == CW'(BYTES - 1));

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            byte_cnt <= '0;
            part_q   <= '0;
         end else if (in_vld) begin
            part_q   <= word_dat[DW-9:0];
            byte_cnt <= word_vld ? '0 : byte_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/iot_filter_gen2.sv
// IoT stream filter: assembles bytes into words, applies MAX/MIN/AVG/EXT/EXC/PMAX/PMIN per word or round.
// Latency: result valid one cycle after the completing byte is accepted.
// Backpressure: valid/out_ready handshake; busy mirrors valid, so input stalls while a result is pending.
// Ports: clk, rst (async, active-high); in_en/iot_in byte input; fn_sel, thr_lo, thr_hi configuration
//        (captured on first byte); out_ready consumer ready; busy, valid, iot_out result side.
module iot_filter_gen2
   import iotdf_pkg::*;
#(
   parameter int BYTES = DEF_BYTES,
   parameter int WORDS = DEF_WORDS,
   localparam int DW = 8 * BYTES
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_en,
   input  logic [7:0]    iot_in,
   input  logic [2:0]    fn_sel,
   input  logic [DW-1:0] thr_lo,
   input  logic [DW-1:0] thr_hi,
   input  logic          out_ready,
   output logic          busy,
   output logic          valid,
   output logic [DW-1:0] iot_out
);

   localparam int LW = $clog2(WORDS);
   localparam int AW = acc_width(DW, WORDS);

   typedef struct packed {
      fn_e           fn;
      logic [DW-1:0] lo;
      logic [DW-1:0] hi;
   } cfg_t;

   logic          accept;
   cfg_t          cfg_live;
   cfg_t          cfg_q;
   cfg_t          cfg;
   logic          cfg_held_q;

   logic [DW-1:0] word;
   logic          word_vld;

   logic [LW-1:0] word_cnt;
   logic          first_word;
   logic          last_word;
   logic [DW-1:0] run_max_q;
   logic [DW-1:0] run_min_q;
   logic [AW-1:0] acc_q;
   logic          seen_round_q;
   logic [DW-1:0] peak_max_q;
   logic [DW-1:0] peak_min_q;

   logic [DW-1:0] rnd_max;
   logic [DW-1:0] rnd_min;
   logic [AW-1:0] rnd_sum;
   logic [DW-1:0] rnd_avg;
   logic          pmax_hit;
   logic          pmin_hit;
   logic          in_window;
   logic          out_window;

   logic          res_vld;
   logic [DW-1:0] res_dat;

   // busy is a registered copy of valid, so it is known at the start of every cycle.
   assign accept = in_en && !busy;

   // ---------------------------------------------------------------
   // Configuration capture: the first accepted byte after reset latches
   // fn_sel and the window. That byte may itself complete a word when
   // BYTES is 1, so the live inputs are used until the capture lands.
   // ---------------------------------------------------------------
   assign cfg_live = '{fn: fn_e'(fn_sel), lo: thr_lo, hi: thr_hi};
   assign cfg      = cfg_held_q ? cfg_q : cfg_live;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_held_q <= 1'b0;
         cfg_q      <= '0;
      end else if (accept && !cfg_held_q) begin
         cfg_held_q <= 1'b1;
         cfg_q      <= cfg_live;
      end
   end

   iotdf_word_asm #(
      .BYTES (BYTES)
   ) u_word_asm (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (accept),
      .in_byte  (iot_in),
      .word_dat (word),
      .word_vld (word_vld)
   );

   // ---------------------------------------------------------------
   // Round statistics. Each value includes the word completing now, so
   // on the last word they are the round's final figures and can be
   // registered straight into the output.
   // ---------------------------------------------------------------
   assign first_word = (word_cnt == '0);
   assign last_word  = (word_cnt == LW'(WORDS - 1));

   assign rnd_max = (first_word || word > run_max_q) ? word : run_max_q;
   assign rnd_min = (first_word || word < run_min_q) ? word : run_min_q;
   assign rnd_sum = first_word ? AW'(word) : acc_q + AW'(word);
   // WORDS is a power of two, so the floor division is a plain shift.
   assign rnd_avg = rnd_sum[AW-1:LW];

   // Round 0 always reports and seeds the peak, whatever the peak holds.
   assign pmax_hit = !seen_round_q || (rnd_max > peak_max_q);
   assign pmin_hit = !seen_round_q || (rnd_min < peak_min_q);

   // Equality with either bound is excluded in both modes; the explicit
   // inequality terms matter when the window is inverted (lo >= hi).
   assign in_window  = (word > cfg.lo) && (word < cfg.hi);
   assign out_window = ((word < cfg.lo) || (word > cfg.hi)) &&
                       (word != cfg.lo) && (word != cfg.hi);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt     <= '0;
         run_max_q    <= '0;
         run_min_q    <= '0;
         acc_q        <= '0;
         seen_round_q <= 1'b0;
         peak_max_q   <= '0;
         peak_min_q   <= '1;
      end else if (word_vld) begin
         word_cnt  <= word_cnt + LW'(1);
         run_max_q <= rnd_max;
         run_min_q <= rnd_min;
         acc_q     <= rnd_sum;
         if (last_word) begin
            seen_round_q <= 1'b1;
            if (pmax_hit) peak_max_q <= rnd_max;
            if (pmin_hit) peak_min_q <= rnd_min;
         end
      end
   end

   // ---------------------------------------------------------------
   // Result selection for the word completing this cycle.
   // ---------------------------------------------------------------
   always_comb begin
      res_vld = 1'b0;
      res_dat = '0;
      if (word_vld) begin
         case (cfg.fn)
            FN_MAX:  if (last_word) begin res_vld = 1'b1; res_dat = rnd_max; end
            FN_MIN:  if (last_word) begin res_vld = 1'b1; res_dat = rnd_min; end
            FN_AVG:  if (last_word) begin res_vld = 1'b1; res_dat = rnd_avg; end
            FN_EXT:  if (in_window) begin res_vld = 1'b1; res_dat = word; end
            FN_EXC:  if (out_window) begin res_vld = 1'b1; res_dat = word; end
            FN_PMAX: if (last_word && pmax_hit) begin res_vld = 1'b1; res_dat = rnd_max; end
            FN_PMIN: if (last_word && pmin_hit) begin res_vld = 1'b1; res_dat = rnd_min; end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Output handshake. A new result can only appear while busy is low,
   // i.e. when nothing is pending, so load and release never collide.
   // iot_out is zeroed on release to stay 0 while valid is low.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid   <= 1'b0;
         busy    <= 1'b0;
         iot_out <= '0;
      end else if (res_vld) begin
         valid   <= 1'b1;
         busy    <= 1'b1;
         iot_out <= res_dat;
      end else if (valid && out_ready) begin
         valid   <= 1'b0;
         busy    <= 1'b0;
         iot_out <= '0;
      end
   end

endmodule
